// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU with valid/ready issue and writeback handshakes.
// Single-cycle logic/add/sub/shift ops, iterative shift-add multiply and,
// when ALU_ITER_DIV_EN is defined, iterative restoring divide (op 12).
// Ports: clk_i/rst_i (async active-high reset); in_valid_i/in_ready_o with
// op_i, a_i, b_i, flags_in_i {SF,ZF,PF,OF,CF}; out_valid_o/out_ready_i with
// result_o, result_hi_o, flags_out_o, wef_o, illegal_o; busy_o during ITER.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       flags_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [4:0]       flags_out_o,
  output logic             wef_o,
  output logic             illegal_o,
  output logic             busy_o
);
  localparam int LW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic last_q, last_d, neg_q, neg_d, wef_q, wef_d, ill_q, ill_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d, rhi_q, rhi_d;
  logic [4:0] flg_q, flg_d, s_flags;
  logic accept, is_iter, is_div, s_of, s_cf, s_keep, s_ill, mul_of;
  logic [LW-1:0] sh;
  logic [WIDTH:0] add_w, sll_w, srl_w, sra_w, mul_w;
  logic [WIDTH-1:0] s_res, add_a, add_b, mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
`ifdef ALU_ITER_DIV_EN
  logic [WIDTH:0] div_w;
  logic div_ok;
  assign is_div = op_i == 4'd12;
`else
  assign is_div = 1'b0;
`endif
  assign in_ready_o = (state_q == IDLE) | (state_q == DONE & out_ready_i);
  assign accept = in_valid_i & in_ready_o;
  assign is_iter = op_i == 4'd10 | op_i == 4'd11 | is_div;
  assign out_valid_o = state_q == DONE;
  assign busy_o = state_q == ITER;
  assign result_o = res_q;
  assign result_hi_o = rhi_q;
  assign flags_out_o = flg_q;
  assign wef_o = wef_q & out_valid_o;
  assign illegal_o = ill_q & out_valid_o;
  // single-cycle datapath, evaluated directly on the offered operands
  always_comb begin
    sh = b_i[LW-1:0];
    add_a = op_i == 4'd5 ? '0 : a_i;
    add_b = op_i == 4'd0 ? b_i : ~b_i;
    add_w = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, op_i != 4'd0};
    sll_w = {1'b0, a_i} << sh;
    srl_w = {a_i, 1'b0} >> sh;
    sra_w = $signed({a_i, 1'b0}) >>> sh;
    s_res = b_i;
    s_of = 1'b0;
    s_cf = 1'b0;
    s_keep = 1'b0;
    s_ill = 1'b0;
    case (op_i)
      4'd0: begin
        s_res = add_w[WIDTH-1:0];
        s_of = (a_i[WIDTH-1] ~^ b_i[WIDTH-1]) & (a_i[WIDTH-1] ^ add_w[WIDTH-1]);
        s_cf = add_w[WIDTH];
      end
      4'd1: s_res = a_i | b_i;
      4'd2: s_res = a_i & b_i;
      4'd3: s_res = a_i ^ b_i;
      4'd4: begin
        s_res = add_w[WIDTH-1:0];
        s_of = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (a_i[WIDTH-1] ^ add_w[WIDTH-1]);
        s_cf = ~add_w[WIDTH];
      end
      4'd5: begin
        s_res = add_w[WIDTH-1:0];
        s_of = b_i == {1'b1, {(WIDTH-1){1'b0}}};
        s_cf = ~add_w[WIDTH];
      end
      4'd6: begin
        s_res = ~b_i;
        s_keep = 1'b1;
      end
      4'd7: begin
        s_res = sll_w[WIDTH-1:0];
        s_cf = sll_w[WIDTH];
        s_of = sll_w[WIDTH-1] ^ sll_w[WIDTH];
      end
      4'd8: begin
        s_res = srl_w[WIDTH:1];
        s_cf = srl_w[0];
        s_of = a_i[WIDTH-1];
      end
      4'd9: begin
        s_res = sra_w[WIDTH:1];
        s_cf = sra_w[0];
      end
      default: begin
        s_keep = 1'b1;
        s_ill = 1'b1;
      end
    endcase
    if (op_i inside {4'd7, 4'd8, 4'd9} && sh == '0) {s_of, s_cf} = flags_in_i[1:0];
    s_flags = s_keep ? flags_in_i : {s_res[WIDTH-1], s_res == '0, ~^s_res[7:0], s_of, s_cf};
  end
  // one radix-2 step: multiply adds m into hi when the low multiplier bit is set
  always_comb begin
    mul_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    mul_of = op_q == 4'd10 ? prod[2*WIDTH-1:WIDTH] != '0 : prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    mag_a = (op_i == 4'd11 && a_i[WIDTH-1]) ? -a_i : a_i;
    mag_b = (op_i == 4'd11 && b_i[WIDTH-1]) ? -b_i : b_i;
`ifdef ALU_ITER_DIV_EN
    div_w = {hi_q, lo_q[WIDTH-1]} - {1'b0, m_q};
    div_ok = ~div_w[WIDTH] | (m_q == '0);
`endif
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    neg_d = neg_q;
    op_d = op_q;
    m_d = m_q;
    hi_d = hi_q;
    lo_d = lo_q;
    res_d = res_q;
    rhi_d = rhi_q;
    flg_d = flg_q;
    wef_d = wef_q;
    ill_d = ill_q;
    if (accept && is_iter) begin
      state_d = ITER;
      cnt_d = {LW{1'b1}};
      last_d = 1'b0;
      op_d = op_i;
      neg_d = op_i == 4'd11 && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      m_d = is_div ? b_i : mag_a;
      hi_d = '0;
      lo_d = is_div ? a_i : mag_b;
    end else if (accept) begin
      state_d = DONE;
      res_d = s_res;
      rhi_d = '0;
      flg_d = s_flags;
      wef_d = ~s_keep;
      ill_d = s_ill;
    end else if (state_q == DONE && out_ready_i) begin
      state_d = IDLE;
    end else if (state_q == ITER && last_q) begin
      // all steps done: apply sign correction and flags on the way to DONE
      state_d = DONE;
      wef_d = 1'b1;
      ill_d = 1'b0;
      {rhi_d, res_d} = prod;
      flg_d = {prod[2*WIDTH-1], prod == '0, ~^prod[7:0], mul_of, mul_of};
`ifdef ALU_ITER_DIV_EN
      if (op_q == 4'd12) begin
        res_d = lo_q;
        rhi_d = hi_q;
        flg_d = {lo_q[WIDTH-1], lo_q == '0, ~^lo_q[7:0], m_q == '0, 1'b0};
      end
`endif
    end else if (state_q == ITER) begin
      cnt_d = cnt_q - 1'b1;
      last_d = cnt_q == '0;
      hi_d = mul_w[WIDTH:1];
      lo_d = {mul_w[0], lo_q[WIDTH-1:1]};
`ifdef ALU_ITER_DIV_EN
      // restoring step; a zero divisor always "fits", giving all-ones / A
      if (op_q == 4'd12) begin
        hi_d = div_ok ? div_w[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], div_ok};
      end
`endif
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b0;
      neg_q <= 1'b0;
      op_q <= '0;
      m_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      res_q <= '0;
      rhi_q <= '0;
      flg_q <= '0;
      wef_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      neg_q <= neg_d;
      op_q <= op_d;
      m_q <= m_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      res_q <= res_d;
      rhi_q <= rhi_d;
      flg_q <= flg_d;
      wef_q <= wef_d;
      ill_q <= ill_d;
    end
  end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter at WIDTH=32.
module tb_alu_iter;
  localparam int W = 32;
`ifdef ALU_ITER_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic rst_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, wef_o, illegal_o, busy_o;
  logic [3:0] op_i;
  logic [W-1:0] a_i, b_i, result_o, result_hi_o;
  logic [4:0] flags_in_i, flags_out_o;
  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic [4:0] f;
    logic w;
    logic il;
    int due;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit seen = 1'b0;
  alu_iter #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .flags_in_i(flags_in_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .result_hi_o(result_hi_o), .flags_out_o(flags_out_o), .wef_o(wef_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] fi);
    exp_t e;
    logic [63:0] p;
    longint s;
    int n;
    logic of, cf;
    bit mul, rsv;
    n = int'(b[4:0]);
    of = 1'b0;
    cf = 1'b0;
    mul = 1'b0;
    rsv = 1'b0;
    p = '0;
    e.r = '0;
    e.h = '0;
    e.w = 1'b1;
    e.il = 1'b0;
    e.due = 0;
    case (op)
      4'd0: begin
        e.r = a + b;
        p = 64'(a) + 64'(b);
        cf = p[32];
        s = longint'($signed(a)) + longint'($signed(b));
        of = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      4'd1: e.r = a | b;
      4'd2: e.r = a & b;
      4'd3: e.r = a ^ b;
      4'd4: begin
        e.r = a - b;
        cf = a < b;
        s = longint'($signed(a)) - longint'($signed(b));
        of = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      4'd5: begin
        e.r = -b;
        of = b == 32'h8000_0000;
        cf = b != 0;
      end
      4'd6: e.r = ~b;
      4'd7: begin
        e.r = a << n;
        if (n != 0) begin
          cf = a[32-n];
          of = e.r[31] ^ cf;
        end
      end
      4'd8: begin
        e.r = a >> n;
        if (n != 0) begin
          cf = a[n-1];
          of = a[31];
        end
      end
      4'd9: begin
        e.r = $signed(a) >>> n;
        if (n != 0) cf = a[n-1];
      end
      4'd10: begin
        mul = 1'b1;
        p = 64'(a) * 64'(b);
        of = p[63:32] != 0;
        cf = of;
      end
      4'd11: begin
        mul = 1'b1;
        p = longint'($signed(a)) * longint'($signed(b));
        of = p[63:32] != {32{p[31]}};
        cf = of;
      end
      4'd12: begin
        if (DIV && b == 0) begin
          e.r = '1;
          e.h = a;
          of = 1'b1;
        end else if (DIV) begin
          e.r = a / b;
          e.h = a % b;
        end else rsv = 1'b1;
      end
      default: rsv = 1'b1;
    endcase
    if (op inside {4'd7, 4'd8, 4'd9} && n == 0) {of, cf} = fi[1:0];
    if (rsv) begin
      e.r = b;
      e.w = 1'b0;
      e.il = 1'b1;
      e.f = fi;
    end else if (op == 4'd6) begin
      e.w = 1'b0;
      e.f = fi;
    end else if (mul) begin
      {e.h, e.r} = p;
      e.f = {p[63], p == 0, ~^p[7:0], of, cf};
    end else e.f = {e.r[31], e.r == 0, ~^e.r[7:0], of, cf};
    return e;
  endfunction
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] fi);
    exp_t e;
    int n;
    op_i = op;
    a_i = a;
    b_i = b;
    flags_in_i = fi;
    in_valid_i = 1'b1;
    #1;
    n = 0;
    while (!in_ready_o && n < 100) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (!in_ready_o) chk("issue_timeout", 64'(in_ready_o), 64'(1));
    e = model(op, a, b, fi);
    e.due = cyc + ((op == 4'd10 || op == 4'd11 || (op == 4'd12 && DIV)) ? W + 2 : 1);
    sb.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
  endtask
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o) begin
      if (sb.size() == 0) chk("spurious_valid", 64'(out_valid_o), 64'(0));
      else begin
        me = sb[0];
        if (!seen) begin
          chk("latency", 64'(cyc), 64'(me.due));
          seen = 1'b1;
        end
        chk("result", 64'(result_o), 64'(me.r));
        chk("result_hi", 64'(result_hi_o), 64'(me.h));
        chk("flags", 64'(flags_out_o), 64'(me.f));
        chk("wef", 64'(wef_o), 64'(me.w));
        chk("illegal", 64'(illegal_o), 64'(me.il));
      end
    end
  end
  always @(posedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i && sb.size() != 0) begin
      void'(sb.pop_front());
      seen = 1'b0;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    op_i = '0;
    a_i = '0;
    b_i = '0;
    flags_in_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_in_ready", 64'(in_ready_o), 64'(1));
    chk("rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("rst_outputs", {result_o, result_hi_o}, 64'(0));
    chk("rst_misc", 64'({flags_out_o, wef_o, illegal_o, busy_o}), 64'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'b00000);
    issue(4'd11, 32'hFFFF_FFFE, 32'h0000_0003, 5'b00000);
    chk("muls_busy", 64'(busy_o), 64'(1));
    chk("muls_not_valid", 64'(out_valid_o), 64'(0));
    drain();
    issue(4'd12, 32'd100, 32'd7, 5'b00000);
    issue(4'd12, 32'd100, 32'd0, 5'b00000);
    drain();
    out_ready_i = 1'b0;
    issue(4'd4, 32'd5, 32'd5, 5'b00000);
    repeat (5) begin
      @(negedge clk_i);
      #1;
      chk("stall_in_ready", 64'(in_ready_o), 64'(0));
    end
    out_ready_i = 1'b1;
    issue(4'd3, 32'hA5A5_0F0F, 32'h0F0F_FFFF, 5'b00000);
    issue(4'd1, 32'h1234_0000, 32'h0000_5678, 5'b00000);
    issue(4'd10, 32'd1234, 32'd5678, 5'b00000);
    repeat (9) @(negedge clk_i);
    #1;
    chk("pre_rst_busy", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    #1;
    chk("async_out_valid", 64'(out_valid_o), 64'(0));
    chk("async_busy", 64'(busy_o), 64'(0));
    chk("async_result", {result_o, result_hi_o}, 64'(0));
    sb.delete();
    seen = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready_o), 64'(1));
    issue(4'd0, 32'd2, 32'd3, 5'b00000);
    issue(4'd7, 32'h8000_0001, 32'd1, 5'b00000);
    issue(4'd7, 32'h8000_0001, 32'd0, 5'b00011);
    issue(4'd8, 32'h8000_0003, 32'd2, 5'b00000);
    issue(4'd9, 32'h8000_0004, 32'd3, 5'b00000);
    issue(4'd9, 32'h8000_0004, 32'd0, 5'b00010);
    issue(4'd5, 32'd0, 32'h8000_0000, 5'b00000);
    issue(4'd5, 32'd0, 32'd0, 5'b00000);
    issue(4'd6, 32'd0, 32'h00FF_00FF, 5'b10101);
    issue(4'd14, 32'd9, 32'hDEAD_BEEF, 5'b01010);
    issue(4'd12, 32'd9, 32'h0000_0003, 5'b00101);
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00000);
    issue(4'd11, 32'h8000_0000, 32'h8000_0000, 5'b00000);
    issue(4'd11, 32'h7FFF_FFFF, 32'h0000_0000, 5'b00000);
    issue(4'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'b00000);
    drain();
    for (int i = 0; i < 24; i++) begin
      issue(4'($urandom_range(0, 15)), $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            5'($urandom));
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
